// File: rtl/adc_sample_fifo.sv
// ADC sample capture: detects completed RD windows, averages 2^AVG_LOG2 samples
// and buffers the averages in a show-ahead FIFO behind a valid/ready stream.
module adc_sample_fifo #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int FIFO_AW  = 4
) (
  input  logic               clk_100M,
  input  logic               reset,
  input  logic               enable,
  input  logic               adc_rd,
  input  logic [DATA_W-1:0]  sample_in,
  input  logic               clear_ovf,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic [15:0]        sample_count
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  // With AVG_LOG2=0 the last-count value is 0, so every strobe pushes.
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [FIFO_AW:0]   LEVEL_MAX = (FIFO_AW + 1)'(DEPTH);

  logic               rd_q, rd_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push_q, push_d;
  logic [DATA_W-1:0]  push_data_q, push_data_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        count_q, count_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               strb;
  logic [ACC_W-1:0]   sum;
  logic               full, pop, wr_en, drop;

  always_comb begin
    rd_d        = adc_rd;
    strb        = enable & adc_rd & ~rd_q;
    sum         = acc_q + ACC_W'(sample_in);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (strb) begin
      if (cnt_q == CNT_LAST) begin
        push_d      = 1'b1;
        push_data_d = DATA_W'(sum >> AVG_LOG2);
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    m_valid    = (level_q != '0);
    full       = (level_q == LEVEL_MAX);
    pop        = m_valid & m_ready;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    wr_en      = push_q & (~full | pop);
    drop       = push_q & full & ~pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    count_d    = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    overflow_d = drop | (overflow_q & ~clear_ovf);
  end

  always_ff @(posedge clk_100M or negedge reset) begin
    if (!reset) begin
      rd_q        <= 1'b1;
      acc_q       <= '0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      rd_q        <= rd_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_100M) begin
    if (wr_en) mem[wr_ptr_q] <= push_data_q;
  end

  // Empty FIFO presents zero rather than stale array contents.
  assign m_data       = m_valid ? mem[rd_ptr_q] : '0;
  assign fifo_level   = level_q;
  assign overflow     = overflow_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo: expected averages are queued when the
// reads are driven and compared as the FIFO delivers them.
module tb_adc_sample_fifo;

  logic        clk_100M = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        adc_rd = 1'b1;
  logic [7:0]  sample_in = '0;
  logic        clear_ovf = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] sample_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb_q [$];

  adc_sample_fifo #(.DATA_W(8), .AVG_LOG2(2), .FIFO_AW(4)) dut (
    .clk_100M(clk_100M), .reset(reset), .enable(enable), .adc_rd(adc_rd),
    .sample_in(sample_in), .clear_ovf(clear_ovf), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
    .overflow(overflow), .sample_count(sample_count)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One RD window of low_cycles cycles, then RD high with the sample held.
  task automatic do_read(input logic [7:0] val, input int low_cycles);
    adc_rd = 1'b0;
    for (int i = 0; i < low_cycles; i++) tick();
    adc_rd    = 1'b1;
    sample_in = val;
    tick();
  endtask

  task automatic read_window(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input int low_cycles);
    logic [9:0] s;
    do_read(a, low_cycles);
    do_read(b, low_cycles);
    do_read(c, low_cycles);
    do_read(d, low_cycles);
    s = 10'(a) + 10'(b) + 10'(c) + 10'(d);
    sb_q.push_back(8'(s >> 2));
  endtask

  task automatic drain();
    int guard = 0;
    m_ready = 1'b1;
    while (sb_q.size() > 0 && guard < 64) begin
      chk("drain_valid", 32'(m_valid), 32'd1);
      chk("drain_data", 32'(m_data), 32'(sb_q[0]));
      $display("[TB] pop data=%0h expected=%0h", m_data, sb_q[0]);
      void'(sb_q.pop_front());
      tick();
      guard++;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    m_ready = 1'b0;
    chk("drain_empty_level", 32'(fifo_level), 32'd0);
    chk("drain_empty_valid", 32'(m_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    enable = 1'b1;
    #12;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_count", 32'(sample_count), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    reset = 1'b1;
    tick();

    // Basic average and push latency.
    read_window(8'd10, 8'd20, 8'd30, 8'd41, 1);
    chk("lat_valid_T1", 32'(m_valid), 32'd0);
    tick();
    chk("lat_valid_T2", 32'(m_valid), 32'd1);
    chk("avg_data", 32'(m_data), 32'd25);
    chk("avg_level", 32'(fifo_level), 32'd1);
    chk("avg_count", 32'(sample_count), 32'd1);
    $display("[TB] avg window data=%0h level=%0d", m_data, fifo_level);
    tick();
    chk("avg_level_hold", 32'(fifo_level), 32'd1);
    drain();

    // Long RD windows, full-scale samples.
    read_window(8'hFF, 8'hFF, 8'hFF, 8'hFF, 5);
    read_window(8'hFF, 8'hFF, 8'hFF, 8'hFF, 5);
    tick(); tick();
    chk("long_level", 32'(fifo_level), 32'd2);
    chk("long_count", 32'(sample_count), 32'd3);
    drain();

    // Fill to overflow from a fresh reset.
    do_reset();
    chk("rst2_count", 32'(sample_count), 32'd0);
    for (int w = 0; w < 17; w++) begin
      do_read(8'd1, 1); do_read(8'd1, 1); do_read(8'd1, 1); do_read(8'd1, 1);
      if (w < 16) sb_q.push_back(8'd1);
    end
    tick(); tick();
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_count", 32'(sample_count), 32'd16);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Push coinciding with a pop while full.
    do_read(8'd4, 1); do_read(8'd4, 1); do_read(8'd4, 1);
    adc_rd = 1'b0;
    tick();
    adc_rd    = 1'b1;
    sample_in = 8'd4;
    tick();
    m_ready = 1'b1;
    chk("pp_head", 32'(m_data), 32'(sb_q[0]));
    void'(sb_q.pop_front());
    sb_q.push_back(8'd4);
    tick();
    chk("pp_level", 32'(fifo_level), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_count", 32'(sample_count), 32'd17);
    drain();

    // Enable drop discards a partial window.
    do_read(8'd99, 1); do_read(8'd99, 1);
    enable = 1'b0;
    tick(); tick(); tick();
    enable = 1'b1;
    read_window(8'd8, 8'd8, 8'd8, 8'd8, 1);
    tick(); tick();
    chk("en_level", 32'(fifo_level), 32'd1);
    chk("en_count", 32'(sample_count), 32'd18);
    drain();

    // Reset mid-window.
    do_read(8'd50, 1); do_read(8'd50, 1);
    #2;
    reset = 1'b0;
    #2;
    chk("amw_count", 32'(sample_count), 32'd0);
    chk("amw_level", 32'(fifo_level), 32'd0);
    reset = 1'b1;
    tick();
    read_window(8'd3, 8'd5, 8'd7, 8'd9, 1);
    tick(); tick();
    chk("amw_fresh_count", 32'(sample_count), 32'd1);
    drain();

    // Reset mid-drain.
    read_window(8'd20, 8'd20, 8'd20, 8'd20, 1);
    read_window(8'd40, 8'd40, 8'd40, 8'd40, 1);
    tick(); tick();
    chk("amd_level", 32'(fifo_level), 32'd2);
    m_ready = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    #2;
    chk("amd_valid", 32'(m_valid), 32'd0);
    chk("amd_level0", 32'(fifo_level), 32'd0);
    chk("amd_count0", 32'(sample_count), 32'd0);
    chk("amd_data0", 32'(m_data), 32'd0);
    chk("amd_ovf0", 32'(overflow), 32'd0);
    m_ready = 1'b0;
    sb_q.delete();
    reset = 1'b1;
    tick();
    read_window(8'd100, 8'd101, 8'd102, 8'd104, 1);
    tick(); tick();
    chk("amd_fresh_level", 32'(fifo_level), 32'd1);
    chk("amd_fresh_count", 32'(sample_count), 32'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
